// File: rtl/tetris_pkg.sv
// Shared tetris definitions: board size defaults, piece-type codes, the
// refresh FSM state encoding and the shape table used by the board,
// collision and display logic.
//
// Piece codes run alphabetically: I=1, J=2, L=3, O=4, S=5, T=6, Z=7; 0 = none.
// A shape mask has bit (r*4+c) set for the occupied cell at row r, column c
// of the 4x4 piece box. Every shape is packed into the top-left of the box.
package tetris_pkg;

  localparam int COLS_DEF = 10;
  localparam int ROWS_DEF = 20;

  localparam logic [2:0] PIECE_NONE = 3'd0;
  localparam logic [2:0] PIECE_I    = 3'd1;
  localparam logic [2:0] PIECE_J    = 3'd2;
  localparam logic [2:0] PIECE_L    = 3'd3;
  localparam logic [2:0] PIECE_O    = 3'd4;
  localparam logic [2:0] PIECE_S    = 3'd5;
  localparam logic [2:0] PIECE_T    = 3'd6;
  localparam logic [2:0] PIECE_Z    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK,
    ST_SCAN,
    ST_SHIFT,
    ST_DONE
  } refresh_state_t;

  function automatic logic [15:0] shape_mask(input logic [2:0] ptype,
                                             input logic [1:0] pdir);
    logic [15:0] m;
    m = 16'h0000;
    case (ptype)
      // I, S and Z have only two distinct orientations; dir[0] selects.
      PIECE_I: m = pdir[0] ? 16'h1111 : 16'h000F;
      PIECE_O: m = 16'h0033;
      PIECE_S: m = pdir[0] ? 16'h0231 : 16'h0036;
      PIECE_Z: m = pdir[0] ? 16'h0132 : 16'h0063;
      PIECE_T: begin
        case (pdir)
          2'd0:    m = 16'h0027;
          2'd1:    m = 16'h0232;
          2'd2:    m = 16'h0072;
          default: m = 16'h0131;
        endcase
      end
      PIECE_J: begin
        case (pdir)
          2'd0:    m = 16'h0071;
          2'd1:    m = 16'h0113;
          2'd2:    m = 16'h0047;
          default: m = 16'h0322;
        endcase
      end
      PIECE_L: begin
        case (pdir)
          2'd0:    m = 16'h0074;
          2'd1:    m = 16'h0311;
          2'd2:    m = 16'h0017;
          default: m = 16'h0223;
        endcase
      end
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tetromino_shape.sv
// Combinational piece-shape lookup.
//  ptype  in  3   piece type (0 = none)
//  dir    in  2   rotation
//  mask   out 16  occupied cells of the 4x4 box, bit r*4+c
module tetromino_shape
  import tetris_pkg::*;
(
  input  logic [2:0]  ptype,
  input  logic [1:0]  dir,
  output logic [15:0] mask
);

  assign mask = shape_mask(ptype, dir);

endmodule

// File: rtl/board_refresh.sv
// Board storage plus lock/line-clear sequencer for the piece controller.
// On a one-cycle refresh pulse the falling piece is ORed into the board,
// full rows are removed bottom-up, and refresh_done pulses for one cycle.
//  clk           in   1     clock
//  rstn          in   1     async active-low reset
//  refresh       in   1     lock request (only honoured when idle)
//  x, y          in   5     piece box origin (column, row)
//  ptype         in   3     piece type 1..7, 0 = no piece ("type" is reserved)
//  dir           in   2     rotation 0..3
//  rd_row        in   5     read-port row select
//  rd_data       out  COLS  board[rd_row], 0 when rd_row >= ROWS
//  refresh_done  out  1     lock + clear complete
//  busy          out  1     not idle
//  lines         out  16    rows cleared since reset (wraps)
//  last_clear    out  3     rows cleared by the latest refresh
module board_refresh
  import tetris_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            refresh,
  input  logic [4:0]      x,
  input  logic [4:0]      y,
  input  logic [2:0]      ptype,
  input  logic [1:0]      dir,
  input  logic [4:0]      rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            refresh_done,
  output logic            busy,
  output logic [15:0]     lines,
  output logic [2:0]      last_clear
);

  refresh_state_t  state;
  logic [4:0]      px, py;
  logic [2:0]      pt;
  logic [1:0]      pd;
  logic [4:0]      r;
  logic [2:0]      cnt;
  logic [COLS-1:0] board [ROWS];

  logic [15:0]     mask;
  logic [COLS-1:0] lock_bits [ROWS];
  logic [ROWS-1:0] row_full;
  logic            full_r;   // board[r] full
  logic            full_up;  // board[r-1] full, i.e. the row a shift brings down

  tetromino_shape u_shape (
    .ptype (pt),
    .dir   (pd),
    .mask  (mask)
  );

  // Project the 4x4 mask onto the board. Cells landing outside the board
  // simply have no matching (i,j) and are dropped, so nothing wraps.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        int dr, dc;
        dr = i - int'(py);
        dc = j - int'(px);
        lock_bits[i][j] = 1'b0;
        if (dr >= 0 && dr < 4 && dc >= 0 && dc < 4)
          lock_bits[i][j] = mask[4'(dr * 4 + dc)];
      end
    end
  end

  always_comb begin
    full_r  = 1'b0;
    full_up = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      row_full[i] = &board[i];
      if (5'(i) == r) full_r = &board[i];
    end
    for (int i = 0; i < ROWS - 1; i++)
      if (5'(i) + 5'd1 == r) full_up = &board[i];
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < ROWS; i++)
      if (5'(i) == rd_row) rd_data = board[i];
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      px           <= '0;
      py           <= '0;
      pt           <= PIECE_NONE;
      pd           <= '0;
      r            <= '0;
      cnt          <= '0;
      refresh_done <= 1'b0;
      lines        <= '0;
      last_clear   <= '0;
      for (int i = 0; i < ROWS; i++) board[i] <= '0;
    end else begin
      refresh_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (refresh) begin
            px    <= x;
            py    <= y;
            pt    <= ptype;
            pd    <= dir;
            state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          for (int i = 0; i < ROWS; i++) board[i] <= board[i] | lock_bits[i];
          r     <= 5'(ROWS - 1);
          cnt   <= '0;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (full_r) begin
            state <= ST_SHIFT;
          end else if (r == '0) begin
            refresh_done <= 1'b1;
            state        <= ST_DONE;
          end else begin
            r <= r - 5'd1;
          end
        end
        ST_SHIFT: begin
          // Drop rows 0..r-1 down by one. The row being shifted into r is
          // examined in this same cycle, so each cleared row costs exactly
          // one extra cycle and stacked full rows stay in SHIFT.
          board[0] <= '0;
          for (int i = 1; i < ROWS; i++)
            if (5'(i) <= r) board[i] <= board[i-1];
          cnt <= cnt + 3'd1;
          if (full_up) begin
            state <= ST_SHIFT;
          end else if (r == '0) begin
            refresh_done <= 1'b1;
            state        <= ST_DONE;
          end else begin
            r     <= r - 5'd1;
            state <= ST_SCAN;
          end
        end
        ST_DONE: begin
          last_clear <= cnt;
          lines      <= lines + {13'd0, cnt};
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Row fullness of the whole board; kept for debug visibility.
  logic unused_full;
  assign unused_full = ^row_full;

endmodule

// File: tb/tb_board_refresh.sv
module tb_board_refresh;

  logic        clk = 1'b0;
  logic        rstn;
  logic        refresh;
  logic [4:0]  x, y, rd_row;
  logic [2:0]  ptype;
  logic [1:0]  dir;
  logic [9:0]  rd_data;
  logic        refresh_done, busy;
  logic [15:0] lines;
  logic [2:0]  last_clear;

  board_refresh dut (
    .clk(clk), .rstn(rstn), .refresh(refresh), .x(x), .y(y), .ptype(ptype),
    .dir(dir), .rd_row(rd_row), .rd_data(rd_data), .refresh_done(refresh_done),
    .busy(busy), .lines(lines), .last_clear(last_clear)
  );

  always #5 clk = ~clk;

  typedef struct { int lat; int clr; int lines; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_lines = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input int row, input logic [9:0] exp);
    rd_row = 5'(row);
    #1;
    chk($sformatf("row%0d", row), 32'(rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; refresh = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_lines = 0;
    sb.delete();
  endtask

  // Issues one refresh, pushes the expected outcome, then watches a bounded
  // window, pops the expectation and compares. inj>0 fires a second refresh
  // (I at x=5,y=0) in that cycle, which must be ignored.
  task automatic run_refresh(input logic [4:0] px, input logic [4:0] py,
                             input logic [2:0] pt, input logic [1:0] pd,
                             input int lat, input int clr, input int inj);
    exp_t e;
    int cyc, lat_obs, ndone;
    exp_lines += clr;
    sb.push_back('{lat, clr, exp_lines});
    @(negedge clk);
    x = px; y = py; ptype = pt; dir = pd; refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
    cyc = 1; lat_obs = -1; ndone = 0;
    chk("busy_lock", 32'(busy), 32'd1);
    for (int k = 0; k < 40; k++) begin
      if (refresh_done) begin
        ndone++;
        if (lat_obs < 0) lat_obs = cyc;
      end
      if (cyc == inj) begin
        x = 5'd5; y = 5'd0; ptype = 3'd1; dir = 2'd0; refresh = 1'b1;
      end
      @(posedge clk); #1;
      refresh = 1'b0;
      cyc++;
    end
    e = sb.pop_front();
    chk("latency",    32'(lat_obs),    32'(e.lat));
    chk("done_count", 32'(ndone),      32'd1);
    chk("last_clear", 32'(last_clear), 32'(e.clr));
    chk("lines",      32'(lines),      32'(e.lines & 16'hFFFF));
    chk("busy_idle",  32'(busy),       32'd0);
  endtask

  initial begin
    int nd;
    rstn = 1'b0; refresh = 1'b0; x = '0; y = '0; ptype = '0; dir = '0; rd_row = '0;
    #12;
    // Reset state
    for (int i = 0; i < 32; i++) chk_row(i, 10'h000);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_lines", 32'(lines),        32'd0);
    chk("rst_clear", 32'(last_clear),   32'd0);
    chk("rst_done",  32'(refresh_done), 32'd0);
    @(negedge clk); rstn = 1'b1;

    // O on empty board near the bottom
    do_reset();
    run_refresh(5'd3, 5'd18, 3'd4, 2'd0, 22, 0, -1);
    chk_row(17, 10'h000); chk_row(18, 10'h018); chk_row(19, 10'h018);

    // Single-row clear with content above dropping down
    do_reset();
    run_refresh(5'd4, 5'd19, 3'd1, 2'd0, 22, 0, -1);
    run_refresh(5'd8, 5'd18, 3'd4, 2'd0, 22, 0, -1);
    chk_row(18, 10'h300); chk_row(19, 10'h3F0);
    run_refresh(5'd0, 5'd19, 3'd1, 2'd0, 23, 1, -1);
    chk_row(17, 10'h000); chk_row(18, 10'h000); chk_row(19, 10'h300);

    // Four stacked full rows
    do_reset();
    for (int i = 16; i < 20; i++) begin
      run_refresh(5'd1, 5'(i), 3'd1, 2'd0, 22, 0, -1);
      run_refresh(5'd5, 5'(i), 3'd1, 2'd0, 22, 0, -1);
    end
    run_refresh(5'd9, 5'd16, 3'd1, 2'd1, 22, 0, -1);
    for (int i = 16; i < 20; i++) chk_row(i, 10'h3FE);
    run_refresh(5'd0, 5'd16, 3'd1, 2'd1, 26, 4, -1);
    for (int i = 15; i < 20; i++) chk_row(i, 10'h000);

    // Clipping at the right and bottom edges, no wrap
    do_reset();
    run_refresh(5'd8, 5'd19, 3'd4, 2'd0, 22, 0, -1);
    chk_row(19, 10'h300); chk_row(18, 10'h000); chk_row(0, 10'h000);
    run_refresh(5'd8, 5'd0, 3'd1, 2'd0, 22, 0, -1);
    chk_row(0, 10'h300); chk_row(1, 10'h000);
    run_refresh(5'd0, 5'd18, 3'd1, 2'd1, 22, 0, -1);
    chk_row(18, 10'h001); chk_row(19, 10'h301); chk_row(0, 10'h300); chk_row(1, 10'h000);
    run_refresh(5'd0, 5'd0, 3'd0, 2'd0, 22, 0, -1);
    chk_row(0, 10'h300); chk_row(19, 10'h301);

    // Refresh while busy is dropped
    do_reset();
    run_refresh(5'd0, 5'd18, 3'd4, 2'd0, 22, 0, 5);
    chk_row(0, 10'h000); chk_row(18, 10'h003); chk_row(19, 10'h003);

    // Reset in the middle of a SHIFT
    do_reset();
    run_refresh(5'd0, 5'd19, 3'd1, 2'd0, 22, 0, -1);
    run_refresh(5'd4, 5'd19, 3'd1, 2'd0, 22, 0, -1);
    @(negedge clk);
    x = 5'd8; y = 5'd18; ptype = 3'd4; dir = 2'd0; refresh = 1'b1;
    @(posedge clk); #1; refresh = 1'b0;   // LOCK
    @(posedge clk); #1;                   // SCAN row 19 (full)
    @(posedge clk); #1;                   // SHIFT
    chk("busy_shift", 32'(busy), 32'd1);
    @(negedge clk); rstn = 1'b0; #1;
    chk("rst_mid_busy",  32'(busy),  32'd0);
    chk("rst_mid_lines", 32'(lines), 32'd0);
    for (int i = 0; i < 20; i++) chk_row(i, 10'h000);
    @(negedge clk); rstn = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (refresh_done) nd++;
    end
    chk("rst_mid_nodone", 32'(nd), 32'd0);
    chk("rst_mid_clear",  32'(last_clear), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
